cache_control: RTL and testbench
================================

// Module: cache_control
// PURPOSE
//  Control FSM for the 4-way set-associative, 16-set, 32-byte-line L1 cache.
//  - Consumes the per-way tag/valid/dirty/LRU outputs of cache_datapath and drives
//    all of that datapath's load, mux and write-enable selects.
//  - Handshakes with the CPU-side bus adapter (mem_read/mem_write/mem_resp) and with
//    the physical-memory cacheline port (pmem_read/pmem_write/pmem_resp).
//  - Write-back, write-allocate policy with 3-bit tree pseudo-LRU replacement.
// PARAMETERS
//  s_offset  5   byte-offset bits; index = mem_addr[8:5]
//  s_index   4   set-index bits
//  s_tag     23  tag bits = 32-s_offset-s_index; tag = mem_addr[31:9]
// PORTS
//  clk                       in   1   clock, all state on posedge
//  rst                       in   1   synchronous, active-high reset
//  mem_read/mem_write        in   1   CPU request; held stable until mem_resp
//  mem_addr                  in   32  CPU address
//  mem_resp                  out  1   one-cycle request-done pulse
//  pmem_read/pmem_write      out  1   line fill / line writeback request
//  pmem_address              out  32  line-aligned memory address
//  pmem_resp                 in   1   memory transfer done (one-cycle pulse)
//  tagN_out, N=1..4          in   23  per-way stored tag for current index
//  validN_out/dirtyN_out     in   1   per-way valid/dirty for current index
//  lru_out                   in   3   PLRU bits for current index
//  ld_tagN/ld_validN/ld_dirtyN  out 1  per-way load strobes
//  validN_in/dirtyN_in       out  1   per-way write data
//  ld_lru / lru_in           out  1/3 PLRU update
//  data_arrN_writer_en_ctrl  out  2   00 none, 01 full line, 10 bus_en bytes
//  data_arrN_datain_ctrl     out  1   0 memory line, 1 CPU bus line
//  cacheline_out_ctrl        out  2   way select for read/writeback data (0=way1)
// BEHAVIOUR
//  - Datapath arrays are synchronous-read: outputs are valid one cycle after the index settles.
//  - Reset: state=IDLE; victim reg=0; every output 0 (all strobes/enables inactive,
//    pmem_address=0); takes effect the cycle after rst is sampled, mid-transfer included;
//    pending pmem request is dropped and a later stray pmem_resp is ignored in IDLE.
//  - hitN = validN_out & (tagN_out==mem_addr[31:9]); multiple hits resolve to lowest N.
//  - States:
//    IDLE: outputs inactive; mem_read|mem_write -> CHECK.
//    CHECK, hit way h:
//      - mem_resp=1, cacheline_out_ctrl=h-1, ld_lru=1 with PLRU update; -> IDLE.
//      - Write hit additionally: data_arr_h writer_en=10, datain=1, ld_dirty_h=1, dirty_h_in=1.
//    CHECK, miss:
//      - Latch victim v.
//      - dirty_v=1: pmem_address={tag_v,idx,5'b0} -> WB; else pmem_address={mem_addr[31:5],5'b0} -> FILL.
//    WB: pmem_write=1, cacheline_out_ctrl=v-1; on pmem_resp -> FILL.
//    FILL: pmem_read=1; on pmem_resp the same cycle:
//      - data_arr_v writer_en=01, datain=0.
//      - ld_tag_v=1; ld_valid_v=1 with valid_in=1; ld_dirty_v=1 with dirty_in=0.
//      - -> CHECK; the re-check hits, so LRU/dirty updates happen there.
//  - pmem_read/pmem_write stay high until pmem_resp; never both high.
//  - Latency: hit -> mem_resp 1 cycle after request sampled in IDLE; clean miss adds
//    fill + 1; dirty miss adds writeback + fill + 1.
//  - PLRU, lru[0]=0 victim in {1,2} else {3,4}; lru[1]: 0->1,1->2; lru[2]: 0->3,1->4.
//    Access update: way1 {b0=1,b1=1}, way2 {b0=1,b1=0}, way3 {b0=0,b2=1},
//    way4 {b0=0,b2=0}; the untouched bit is held.
//  - mem_read and mem_write both high is treated as a write.
// CONFIGURATION
//  CACHE_PREFER_INVALID_EN defined: on a miss the lowest-numbered invalid way is the
//    victim, overriding PLRU; PLRU is used only when all 4 ways are valid.
//  Undefined: the victim is always the PLRU way, even if invalid ways exist.
// TESTING
//  - Reset then read 0x0000_0100: clean miss; pmem_read at 0x100, valid_1 load,
//    mem_resp 1 cycle after fill; lru_in=3'b011.
//  - Repeat read 0x0000_0104: hit way1, mem_resp 1 cycle after request,
//    no pmem activity.
//  - Write 0x0000_0100: writer_en1=10, datain1=1, dirty1 loaded 1, mem_resp pulse.
//  - Fill set 8 with tags 0..3, then read tag 4 with victim dirty: pmem_write at
//    {victim_tag,4'h8,5'b0} precedes pmem_read at 0x0000_0900 + tag 4 line.
//  - Macro on, ways 1 and 3 valid, miss -> victim way2; macro off -> PLRU way.
//  - Assert rst during WB: next cycle pmem_write=0, state IDLE; stray pmem_resp ignored.

Source files
------------

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU request and physical-memory line handshake bundle for cache_control
interface cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_addr, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_address
  );

  modport master (
    output mem_read, mem_write, mem_addr, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_address
  );
endinterface

// File: rtl/cache_control.sv
// rtl/cache_control.sv - 4-way write-back L1 cache control FSM with tree PLRU
// Optional CACHE_PREFER_INVALID_EN: miss victim is the lowest invalid way before PLRU.
module cache_control #(
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic             clk,
  input  logic             rst,
  cache_control_if.slave   bus,
  input  logic [s_tag-1:0] tag1_out,
  input  logic [s_tag-1:0] tag2_out,
  input  logic [s_tag-1:0] tag3_out,
  input  logic [s_tag-1:0] tag4_out,
  input  logic             valid1_out,
  input  logic             valid2_out,
  input  logic             valid3_out,
  input  logic             valid4_out,
  input  logic             dirty1_out,
  input  logic             dirty2_out,
  input  logic             dirty3_out,
  input  logic             dirty4_out,
  input  logic [2:0]       lru_out,
  output logic             ld_tag1,
  output logic             ld_tag2,
  output logic             ld_tag3,
  output logic             ld_tag4,
  output logic             ld_valid1,
  output logic             ld_valid2,
  output logic             ld_valid3,
  output logic             ld_valid4,
  output logic             ld_dirty1,
  output logic             ld_dirty2,
  output logic             ld_dirty3,
  output logic             ld_dirty4,
  output logic             valid1_in,
  output logic             valid2_in,
  output logic             valid3_in,
  output logic             valid4_in,
  output logic             dirty1_in,
  output logic             dirty2_in,
  output logic             dirty3_in,
  output logic             dirty4_in,
  output logic             ld_lru,
  output logic [2:0]       lru_in,
  output logic [1:0]       data_arr1_writer_en_ctrl,
  output logic [1:0]       data_arr2_writer_en_ctrl,
  output logic [1:0]       data_arr3_writer_en_ctrl,
  output logic [1:0]       data_arr4_writer_en_ctrl,
  output logic             data_arr1_datain_ctrl,
  output logic             data_arr2_datain_ctrl,
  output logic             data_arr3_datain_ctrl,
  output logic             data_arr4_datain_ctrl,
  output logic [1:0]       cacheline_out_ctrl
);

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

  state_t      state;
  logic [1:0]  victim;
  logic        pmem_read_q;
  logic        pmem_write_q;
  logic [31:0] pmem_address_q;

  logic [s_tag-1:0]   tags [4];
  logic [3:0]         valid, dirty, hit;
  logic [s_tag-1:0]   addr_tag;
  logic [s_index-1:0] addr_idx;
  logic [31:0]        line_addr;
  logic               request, is_write, hit_any;
  logic [1:0]         hit_way, plru_way, victim_next;
  logic [2:0]         lru_next;

  assign tags[0] = tag1_out;
  assign tags[1] = tag2_out;
  assign tags[2] = tag3_out;
  assign tags[3] = tag4_out;
  assign valid   = {valid4_out, valid3_out, valid2_out, valid1_out};
  assign dirty   = {dirty4_out, dirty3_out, dirty2_out, dirty1_out};

  assign addr_tag  = bus.mem_addr[31:s_offset+s_index];
  assign addr_idx  = bus.mem_addr[s_offset+s_index-1:s_offset];
  assign line_addr = {bus.mem_addr[31:s_offset], {s_offset{1'b0}}};
  assign request   = bus.mem_read | bus.mem_write;
  assign is_write  = bus.mem_write;

  always_comb begin
    hit     = '0;
    hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = valid[i] & (tags[i] == addr_tag);
    end
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) hit_way = 2'(i);
    end
  end
  assign hit_any = |hit;

  assign plru_way = lru_out[0] ? (lru_out[2] ? 2'd3 : 2'd2)
                               : (lru_out[1] ? 2'd1 : 2'd0);

`ifdef CACHE_PREFER_INVALID_EN
  logic [1:0] inv_way;
  always_comb begin
    inv_way = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid[i]) inv_way = 2'(i);
    end
  end
  assign victim_next = (&valid) ? plru_way : inv_way;
`else
  assign victim_next = plru_way;
`endif

  // Point the tree away from the accessed way; the bit of the other subtree is held.
  always_comb begin
    lru_next = lru_out;
    case (hit_way)
      2'd0:    lru_next = {lru_out[2], 1'b1, 1'b1};
      2'd1:    lru_next = {lru_out[2], 1'b0, 1'b1};
      2'd2:    lru_next = {1'b1, lru_out[1], 1'b0};
      default: lru_next = {1'b0, lru_out[1], 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      victim         <= 2'd0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) state <= CHECK;
        end
        CHECK: begin
          if (hit_any) begin
            state <= IDLE;
          end else begin
            victim <= victim_next;
            if (dirty[victim_next]) begin
              pmem_address_q <= {tags[victim_next], addr_idx, {s_offset{1'b0}}};
              pmem_write_q   <= 1'b1;
              state          <= WB;
            end else begin
              pmem_address_q <= line_addr;
              pmem_read_q    <= 1'b1;
              state          <= FILL;
            end
          end
        end
        WB: begin
          if (bus.pmem_resp) begin
            pmem_write_q   <= 1'b0;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= line_addr;
            state          <= FILL;
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            pmem_read_q <= 1'b0;
            state       <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath strobes must land in the same cycle as the hit or pmem_resp, so they are decoded.
  logic            resp;
  logic [3:0]      ld_tag_v, ld_valid_v, ld_dirty_v, valid_in_v, dirty_in_v, datain_v;
  logic [3:0][1:0] wen_v;
  logic [1:0]      cl_sel;

  always_comb begin
    resp       = 1'b0;
    ld_tag_v   = '0;
    ld_valid_v = '0;
    ld_dirty_v = '0;
    valid_in_v = '0;
    dirty_in_v = '0;
    datain_v   = '0;
    wen_v      = '0;
    cl_sel     = 2'd0;
    ld_lru     = 1'b0;
    lru_in     = 3'b000;
    case (state)
      CHECK: begin
        if (hit_any) begin
          resp   = 1'b1;
          cl_sel = hit_way;
          ld_lru = 1'b1;
          lru_in = lru_next;
          if (is_write) begin
            wen_v[hit_way]      = 2'b10;
            datain_v[hit_way]   = 1'b1;
            ld_dirty_v[hit_way] = 1'b1;
            dirty_in_v[hit_way] = 1'b1;
          end
        end
      end
      WB: cl_sel = victim;
      FILL: begin
        if (bus.pmem_resp) begin
          wen_v[victim]      = 2'b01;
          ld_tag_v[victim]   = 1'b1;
          ld_valid_v[victim] = 1'b1;
          valid_in_v[victim] = 1'b1;
          ld_dirty_v[victim] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_resp     = resp;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign cacheline_out_ctrl = cl_sel;

  assign {ld_tag4, ld_tag3, ld_tag2, ld_tag1}             = ld_tag_v;
  assign {ld_valid4, ld_valid3, ld_valid2, ld_valid1}     = ld_valid_v;
  assign {ld_dirty4, ld_dirty3, ld_dirty2, ld_dirty1}     = ld_dirty_v;
  assign {valid4_in, valid3_in, valid2_in, valid1_in}     = valid_in_v;
  assign {dirty4_in, dirty3_in, dirty2_in, dirty1_in}     = dirty_in_v;
  assign {data_arr4_datain_ctrl, data_arr3_datain_ctrl,
          data_arr2_datain_ctrl, data_arr1_datain_ctrl}   = datain_v;
  assign data_arr1_writer_en_ctrl = wen_v[0];
  assign data_arr2_writer_en_ctrl = wen_v[1];
  assign data_arr3_writer_en_ctrl = wen_v[2];
  assign data_arr4_writer_en_ctrl = wen_v[3];

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed vector bench for cache_control
module tb_cache_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_control_if bus ();

  logic [22:0] tag1_out, tag2_out, tag3_out, tag4_out;
  logic valid1_out, valid2_out, valid3_out, valid4_out;
  logic dirty1_out, dirty2_out, dirty3_out, dirty4_out;
  logic [2:0] lru_out;
  logic ld_tag1, ld_tag2, ld_tag3, ld_tag4;
  logic ld_valid1, ld_valid2, ld_valid3, ld_valid4;
  logic ld_dirty1, ld_dirty2, ld_dirty3, ld_dirty4;
  logic valid1_in, valid2_in, valid3_in, valid4_in;
  logic dirty1_in, dirty2_in, dirty3_in, dirty4_in;
  logic ld_lru;
  logic [2:0] lru_in;
  logic [1:0] wen1, wen2, wen3, wen4;
  logic din1, din2, din3, din4;
  logic [1:0] cacheline_out_ctrl;

  cache_control dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tag1_out(tag1_out), .tag2_out(tag2_out), .tag3_out(tag3_out), .tag4_out(tag4_out),
    .valid1_out(valid1_out), .valid2_out(valid2_out), .valid3_out(valid3_out), .valid4_out(valid4_out),
    .dirty1_out(dirty1_out), .dirty2_out(dirty2_out), .dirty3_out(dirty3_out), .dirty4_out(dirty4_out),
    .lru_out(lru_out),
    .ld_tag1(ld_tag1), .ld_tag2(ld_tag2), .ld_tag3(ld_tag3), .ld_tag4(ld_tag4),
    .ld_valid1(ld_valid1), .ld_valid2(ld_valid2), .ld_valid3(ld_valid3), .ld_valid4(ld_valid4),
    .ld_dirty1(ld_dirty1), .ld_dirty2(ld_dirty2), .ld_dirty3(ld_dirty3), .ld_dirty4(ld_dirty4),
    .valid1_in(valid1_in), .valid2_in(valid2_in), .valid3_in(valid3_in), .valid4_in(valid4_in),
    .dirty1_in(dirty1_in), .dirty2_in(dirty2_in), .dirty3_in(dirty3_in), .dirty4_in(dirty4_in),
    .ld_lru(ld_lru), .lru_in(lru_in),
    .data_arr1_writer_en_ctrl(wen1), .data_arr2_writer_en_ctrl(wen2),
    .data_arr3_writer_en_ctrl(wen3), .data_arr4_writer_en_ctrl(wen4),
    .data_arr1_datain_ctrl(din1), .data_arr2_datain_ctrl(din2),
    .data_arr3_datain_ctrl(din3), .data_arr4_datain_ctrl(din4),
    .cacheline_out_ctrl(cacheline_out_ctrl)
  );

  logic [7:0] wen_obs;
  logic [3:0] ldd_obs, din_obs, ldt_obs, ldv_obs, vin_obs, dirin_obs;
  assign wen_obs   = {wen4, wen3, wen2, wen1};
  assign ldd_obs   = {ld_dirty4, ld_dirty3, ld_dirty2, ld_dirty1};
  assign din_obs   = {din4, din3, din2, din1};
  assign ldt_obs   = {ld_tag4, ld_tag3, ld_tag2, ld_tag1};
  assign ldv_obs   = {ld_valid4, ld_valid3, ld_valid2, ld_valid1};
  assign vin_obs   = {valid4_in, valid3_in, valid2_in, valid1_in};
  assign dirin_obs = {dirty4_in, dirty3_in, dirty2_in, dirty1_in};

  typedef struct {
    logic rd; logic wr; logic [31:0] addr;
    logic [22:0] t1; logic [22:0] t2; logic [22:0] t3; logic [22:0] t4;
    logic [3:0] v; logic [3:0] d; logic [2:0] lru;
    logic resp; logic [1:0] cl; logic ldl; logic [2:0] lin;
    logic [7:0] wen; logic [3:0] ldd; logic pr; logic pw; logic [31:0] pa;
  } vec_t;

  vec_t vecs [9];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic set_dp(input logic [22:0] t1, t2, t3, t4, input logic [3:0] v, d, input logic [2:0] l);
    tag1_out = t1; tag2_out = t2; tag3_out = t3; tag4_out = t4;
    {valid4_out, valid3_out, valid2_out, valid1_out} = v;
    {dirty4_out, dirty3_out, dirty2_out, dirty1_out} = d;
    lru_out = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    set_dp(vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].t4, vecs[i].v, vecs[i].d, vecs[i].lru);
    bus.mem_addr = vecs[i].addr;
    bus.mem_read = vecs[i].rd;
    bus.mem_write = vecs[i].wr;
    tick();
    chk("mem_resp", i, 32'(bus.mem_resp), 32'(vecs[i].resp));
    chk("cacheline", i, 32'(cacheline_out_ctrl), 32'(vecs[i].cl));
    chk("ld_lru", i, 32'(ld_lru), 32'(vecs[i].ldl));
    chk("lru_in", i, 32'(lru_in), 32'(vecs[i].lin));
    chk("writer_en", i, 32'(wen_obs), 32'(vecs[i].wen));
    chk("ld_dirty", i, 32'(ldd_obs), 32'(vecs[i].ldd));
    chk("dirty_in", i, 32'(dirin_obs), 32'(vecs[i].ldd));
    chk("datain", i, 32'(din_obs), 32'(vecs[i].ldd));
    tick();
    chk("pmem_read", i, 32'(bus.pmem_read), 32'(vecs[i].pr));
    chk("pmem_write", i, 32'(bus.pmem_write), 32'(vecs[i].pw));
    chk("pmem_address", i, bus.pmem_address, vecs[i].pa);
    do_reset();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h104, 23'd0, 23'd0, 23'd0, 23'd0, 4'b0001, 4'b0000, 3'b000,
                1'b1, 2'd0, 1'b1, 3'b011, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h100, 23'd0, 23'd0, 23'd0, 23'd0, 4'b0001, 4'b0000, 3'b000,
                1'b1, 2'd0, 1'b1, 3'b011, 8'b00000010, 4'b0001, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h600, 23'd1, 23'd2, 23'd3, 23'd4, 4'b1111, 4'b0000, 3'b011,
                1'b1, 2'd2, 1'b1, 3'b110, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h800, 23'd1, 23'd2, 23'd3, 23'd4, 4'b1111, 4'b0000, 3'b111,
                1'b1, 2'd3, 1'b1, 3'b010, 8'b10000000, 4'b1000, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h400, 23'd2, 23'd2, 23'd2, 23'd2, 4'b1110, 4'b0000, 3'b100,
                1'b1, 2'd1, 1'b1, 3'b101, 8'h00, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h0, 23'd0, 23'd0, 23'd0, 23'd0, 4'b0001, 4'b0000, 3'b000,
                1'b1, 2'd0, 1'b1, 3'b011, 8'b00000010, 4'b0001, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h1234, 23'd0, 23'd0, 23'd0, 23'd0, 4'b0000, 4'b0000, 3'b000,
                1'b0, 2'd0, 1'b0, 3'b000, 8'h00, 4'b0000, 1'b1, 1'b0, 32'h1220};
    vecs[7] = '{1'b1, 1'b0, 32'h900, 23'd0, 23'd1, 23'h55, 23'd3, 4'b1111, 4'b0100, 3'b001,
                1'b0, 2'd0, 1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b1, 32'hAB00};
`ifdef CACHE_PREFER_INVALID_EN
    vecs[8] = '{1'b1, 1'b0, 32'h900, 23'd1, 23'd2, 23'd3, 23'h77, 4'b0101, 4'b1000, 3'b101,
                1'b0, 2'd0, 1'b0, 3'b000, 8'h00, 4'b0000, 1'b1, 1'b0, 32'h900};
`else
    vecs[8] = '{1'b1, 1'b0, 32'h900, 23'd1, 23'd2, 23'd3, 23'h77, 4'b0101, 4'b1000, 3'b101,
                1'b0, 2'd0, 1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b1, 32'hEF00};
`endif

    bus.mem_addr = 32'h0;
    set_dp(23'd0, 23'd0, 23'd0, 23'd0, 4'b0000, 4'b0000, 3'b000);
    do_reset();
    tick();
    chk("rst_mem_resp", 0, 32'(bus.mem_resp), 32'h0);
    chk("rst_pmem_read", 0, 32'(bus.pmem_read), 32'h0);
    chk("rst_pmem_write", 0, 32'(bus.pmem_write), 32'h0);
    chk("rst_pmem_address", 0, bus.pmem_address, 32'h0);
    chk("rst_writer_en", 0, 32'(wen_obs), 32'h0);
    chk("rst_ld_lru", 0, 32'(ld_lru), 32'h0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Clean miss on 0x100: fill, then the re-check hits way1.
    set_dp(23'd0, 23'd0, 23'd0, 23'd0, 4'b0000, 4'b0000, 3'b000);
    bus.mem_addr = 32'h100; bus.mem_read = 1'b1;
    tick(); tick();
    chk("s1_pmem_read", 1, 32'(bus.pmem_read), 32'h1);
    chk("s1_pmem_address", 1, bus.pmem_address, 32'h100);
    tick(); tick();
    chk("s1_read_held", 1, 32'(bus.pmem_read), 32'h1);
    chk("s1_no_resp_wait", 1, 32'(bus.mem_resp), 32'h0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("s1_fill_wen", 1, 32'(wen_obs), 32'b00000001);
    chk("s1_fill_datain", 1, 32'(din_obs), 32'h0);
    chk("s1_ld_tag", 1, 32'(ldt_obs), 32'b0001);
    chk("s1_ld_valid", 1, 32'({ldv_obs, vin_obs}), 32'b00010001);
    chk("s1_ld_dirty", 1, 32'({ldd_obs, dirin_obs}), 32'b00010000);
    tick();
    bus.pmem_resp = 1'b0;
    set_dp(23'd0, 23'd0, 23'd0, 23'd0, 4'b0001, 4'b0000, 3'b000);
    #1;
    chk("s1_mem_resp", 1, 32'(bus.mem_resp), 32'h1);
    chk("s1_lru_in", 1, 32'(lru_in), 32'b011);
    chk("s1_read_dropped", 1, 32'(bus.pmem_read), 32'h0);
    tick();
    bus.mem_read = 1'b0;
    #1;
    chk("s1_resp_pulse", 1, 32'(bus.mem_resp), 32'h0);
    tick();

    // Dirty miss on set 8: writeback of way3 precedes the fill of 0x900.
    set_dp(23'd0, 23'd1, 23'h55, 23'd3, 4'b1111, 4'b0100, 3'b001);
    bus.mem_addr = 32'h900; bus.mem_read = 1'b1;
    tick(); tick();
    chk("s2_pmem_write", 2, 32'({bus.pmem_write, bus.pmem_read}), 32'b10);
    chk("s2_wb_address", 2, bus.pmem_address, 32'hAB00);
    chk("s2_wb_cacheline", 2, 32'(cacheline_out_ctrl), 32'd2);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    chk("s2_fill_after_wb", 2, 32'({bus.pmem_write, bus.pmem_read}), 32'b01);
    chk("s2_fill_address", 2, bus.pmem_address, 32'h900);
    tick();
    bus.pmem_resp = 1'b1;
    #1;
    chk("s2_fill_wen", 2, 32'(wen_obs), 32'b00010000);
    tick();
    bus.pmem_resp = 1'b0;
    set_dp(23'd0, 23'd1, 23'd4, 23'd3, 4'b1111, 4'b0000, 3'b001);
    #1;
    chk("s2_mem_resp", 2, 32'(bus.mem_resp), 32'h1);
    chk("s2_hit_cacheline", 2, 32'(cacheline_out_ctrl), 32'd2);
    tick();
    bus.mem_read = 1'b0;
    tick();

    // Reset in the middle of a writeback, then a stray pmem_resp in IDLE.
    set_dp(23'd0, 23'd1, 23'h55, 23'd3, 4'b1111, 4'b0100, 3'b001);
    bus.mem_addr = 32'h900; bus.mem_read = 1'b1;
    tick(); tick();
    chk("s3_in_wb", 3, 32'(bus.pmem_write), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_read = 1'b0;
    chk("s3_rst_pmem_write", 3, 32'(bus.pmem_write), 32'h0);
    chk("s3_rst_pmem_address", 3, bus.pmem_address, 32'h0);
    chk("s3_rst_cacheline", 3, 32'(cacheline_out_ctrl), 32'h0);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    chk("s3_stray_pmem", 3, 32'({bus.pmem_read, bus.pmem_write}), 32'h0);
    chk("s3_stray_wen", 3, 32'(wen_obs), 32'h0);
    tick();
    chk("s3_idle_resp", 3, 32'(bus.mem_resp), 32'h0);
    chk("s3_idle_pmem", 3, 32'({bus.pmem_read, bus.pmem_write}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
